// File: rtl/tqvp_jnms_pdm_tx_if.sv
// TinyQV peripheral register bus: address/data/strobes from the CPU, read data back.
interface tqvp_jnms_pdm_tx_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );
endinterface

// File: rtl/tqvp_jnms_pdm_tx.sv
// PDM transmitter: PCM samples from a small FIFO are turned into a 1-bit stream
// by a first-order sigma-delta modulator, clocked out with a programmable pdm_clk.
module tqvp_jnms_pdm_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ui_in,
  output logic [7:0]               uo_out,
  tqvp_jnms_pdm_tx_if.slave        bus,
  output logic                     user_interrupt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ACC_W = SAMPLE_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]          state, state_next;
  logic                strobe;
  logic                en, irq_en;
  logic [7:0]          div, osr;
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [LVL_W-1:0]    level;
  logic                ovf, udr;
  logic [SAMPLE_W-1:0] cur;
  logic [ACC_W-1:0]    acc;
  logic [7:0]          bitcnt, phase;
  logic                pdm_clk, pdm_data;

  // Bus decode
  logic wr_any, wr_ctrl, wr_clr, push_req, flush;
  logic lane1, lane2;
  assign wr_any   = (bus.data_write_n != 2'b11);
  assign lane1    = (bus.data_write_n == 2'b01) || (bus.data_write_n == 2'b10);
  assign lane2    = (bus.data_write_n == 2'b10);
  assign wr_ctrl  = wr_any && (bus.address == 6'h00);
  assign push_req = lane1  && (bus.address == 6'h04);
  assign wr_clr   = wr_any && (bus.address == 6'h08);
  assign flush    = wr_clr && bus.data_in[2];

  // FIFO handshake against pre-cycle state; flush overrides a same-cycle push
  logic empty, full, need, pop, push, underrun, ovf_set;
  assign empty    = (level == '0);
  assign full     = (level == LVL_W'(FIFO_DEPTH));
  assign need     = strobe && (bitcnt == 8'd0);
  assign pop      = need && !empty;
  assign underrun = need && empty;
  assign push     = push_req && !flush && (!full || pop);
  assign ovf_set  = push_req && !flush && full && !pop;

  logic [SAMPLE_W-1:0] used, u;
  logic [ACC_W-1:0]    sum;
  assign used = pop ? mem[rd_ptr] : cur;
  assign u    = used ^ {1'b1, {(SAMPLE_W-1){1'b0}}};
  assign sum  = {1'b0, acc[SAMPLE_W-1:0]} + {1'b0, u};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state; a strobe fires on start-up and on every pdm_clk falling edge
  always_comb begin
    state_next = state;
    strobe     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_next = RUN;
          strobe     = 1'b1;
        end
      end
      RUN: begin
        if (!en)                          state_next = IDLE;
        else if ((phase == div) && pdm_clk) strobe   = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in[SAMPLE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en <= 1'b0; irq_en <= 1'b0; div <= 8'd0; osr <= 8'd0;
      rd_ptr <= '0; wr_ptr <= '0; level <= '0;
      ovf <= 1'b0; udr <= 1'b0; cur <= '0; acc <= '0;
      bitcnt <= 8'd0; phase <= 8'd0; pdm_clk <= 1'b0; pdm_data <= 1'b0;
      user_interrupt <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= bus.data_in[0];
        irq_en <= bus.data_in[1];
        if (lane1) div <= bus.data_in[15:8];
        if (lane2) osr <= bus.data_in[23:16];
      end

      if (flush) begin
        level <= '0; rd_ptr <= '0; wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      level <= level + LVL_W'(1);
        else if (pop && !push) level <= level - LVL_W'(1);
      end

      // Set wins over a same-cycle software clear
      if (ovf_set)                     ovf <= 1'b1;
      else if (wr_clr && bus.data_in[0]) ovf <= 1'b0;
      if (underrun)                    udr <= 1'b1;
      else if (wr_clr && bus.data_in[1]) udr <= 1'b0;

      if (pop) cur <= mem[rd_ptr];

      if (state_next == IDLE) begin
        phase <= 8'd0; pdm_clk <= 1'b0; pdm_data <= 1'b0;
        acc <= '0; bitcnt <= 8'd0;
      end else begin
        if (state == RUN) begin
          if (phase == div) begin
            phase   <= 8'd0;
            pdm_clk <= ~pdm_clk;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        if (strobe) begin
          acc      <= sum;
          pdm_data <= sum[SAMPLE_W];
          bitcnt   <= (bitcnt == osr) ? 8'd0 : bitcnt + 8'd1;
        end
      end

      user_interrupt <= irq_en && en && (level <= LVL_W'(FIFO_DEPTH / 2));
    end
  end

  assign uo_out         = {5'b0, pdm_data, pdm_clk, 1'b0};
  assign bus.data_ready = 1'b1;

  // Read mux, combinational on address
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    case (bus.address)
      6'h00:   rdata = {8'h00, osr, div, 6'h00, irq_en, en};
      6'h04:   rdata = {20'h0, udr, ovf, full, empty, 5'h00, 3'(level)};
      6'h08:   rdata = {{(32-SAMPLE_W){cur[SAMPLE_W-1]}}, cur};
      default: rdata = '0;
    endcase
  end
  assign bus.data_out = rdata;

  logic unused_ok;
  assign unused_ok = ^{ui_in, bus.data_read_n, bus.data_in, acc[SAMPLE_W]};

endmodule
